// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: sequences one LC-3 ADD/AND/NOT through a read / execute /
// writeback pipeline around an external combinational ALU.
// It owns the 8 x 16 register file and the condition codes.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for an instruction; register preload (ld_en) allowed
// READ   | operands fetched from register file / immediate into opX/opY
// EXEC   | ALU result captured into the result register
// WB     | result written to R[DR], nzp updated, done pulsed next cycle
module alu_exec_ctrl (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] IR,
    output logic [15:0] alu_X,
    output logic [15:0] alu_Y,
    output logic [1:0]  alu_sel,
    input  logic [15:0] alu_out,
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [15:0] ld_data,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data,
    output logic        done,
    output logic        illegal,
    output logic [2:0]  nzp
);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        legal_in;
    logic [15:0] ir_q;
    logic [15:0] op_x;
    logic [15:0] op_y;
    logic [1:0]  op_sel;
    logic [15:0] result_q;
    logic [15:0] regs [8];
    logic [15:0] imm5_sext;

    assign legal_in  = (IR[15:12] == OP_ADD) || (IR[15:12] == OP_AND) ||
                       (IR[15:12] == OP_NOT);
    assign imm5_sext = {{11{ir_q[4]}}, ir_q[4:0]};

    assign alu_X    = op_x;
    assign alu_Y    = op_y;
    assign alu_sel  = op_sel;
    assign dbg_data = regs[dbg_addr];

    // State register; reset forces IDLE immediately, aborting any instruction.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; illegal opcodes are accepted but stay in IDLE.
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                accept      = instr_valid;
                if (instr_valid && legal_in) begin
                    state_nxt = S_READ;
                end
            end
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture the instruction word and flag rejected opcodes for one cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ir_q    <= '0;
            illegal <= 1'b0;
        end else begin
            illegal <= accept && !legal_in;
            if (accept) begin
                ir_q <= IR;
            end
        end
    end

    // Operand fetch; NOT ignores the second operand so opY is forced to zero.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            op_x   <= '0;
            op_y   <= '0;
            op_sel <= 2'b11;
        end else if (state == S_READ) begin
            op_x <= regs[ir_q[8:6]];
            if (ir_q[15:12] == OP_NOT) begin
                op_y   <= '0;
                op_sel <= 2'b10;
            end else begin
                op_y   <= ir_q[5] ? imm5_sext : regs[ir_q[2:0]];
                op_sel <= (ir_q[15:12] == OP_ADD) ? 2'b00 : 2'b01;
            end
        end
    end

    // Capture the external ALU output during EXEC.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            result_q <= '0;
        end else if (state == S_EXEC) begin
            result_q <= alu_out;
        end
    end

    // Register file: preload only while idle, writeback on leaving WB.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (state == S_IDLE) begin
            if (ld_en) begin
                regs[ld_addr] <= ld_data;
            end
        end else if (state == S_WB) begin
            regs[ir_q[11:9]] <= result_q;
        end
    end

    // Condition codes and done pulse, both aligned with the register write.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            nzp  <= 3'b000;
            done <= 1'b0;
        end else begin
            done <= (state == S_WB);
            if (state == S_WB) begin
                if (result_q[15]) begin
                    nzp <= 3'b100;
                end else if (result_q == 16'h0000) begin
                    nzp <= 3'b010;
                end else begin
                    nzp <= 3'b001;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: bench-side register model predicts each result,
// pushes it to a scoreboard at issue and pops it when done fires.
module tb_alu_exec_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] IR;
    logic [15:0] alu_X;
    logic [15:0] alu_Y;
    logic [1:0]  alu_sel;
    logic [15:0] alu_out;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic        done;
    logic        illegal;
    logic [2:0]  nzp;

    typedef struct packed {
        logic [2:0]  dr;
        logic [15:0] res;
        logic [2:0]  nzp;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] mr [8];
    logic [2:0]  m_nzp;
    int          n_checks = 0;
    int          n_fail   = 0;

    alu_exec_ctrl dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .IR         (IR),
        .alu_X      (alu_X),
        .alu_Y      (alu_Y),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .done       (done),
        .illegal    (illegal),
        .nzp        (nzp)
    );

    always #5 Clk = ~Clk;

    // External combinational ALU.
    always_comb begin
        alu_out = alu_X;
        case (alu_sel)
            2'b00:   alu_out = alu_X + alu_Y;
            2'b01:   alu_out = alu_X & alu_Y;
            2'b10:   alu_out = ~alu_X;
            default: alu_out = alu_X;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if (v[15]) return 3'b100;
        if (v == 16'h0000) return 3'b010;
        return 3'b001;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge Clk); #1;
        ld_en   = 1'b0;
        mr[a]   = d;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check_val($sformatf("%s_r%0d", tag, i), dbg_data, mr[i]);
        end
    endtask

    // co_ld: preload on the acceptance edge. exec_ld: attempt a preload during EXEC/WB.
    task automatic issue(input logic [15:0] instr, input bit co_ld, input bit exec_ld,
                         input logic [2:0] la, input logic [15:0] ldv);
        logic [15:0] x, y, res;
        logic [1:0]  sel;
        exp_t        e;
        int          n;
        bit          seen;
        if (co_ld) mr[la] = ldv;
        x = mr[instr[8:6]];
        if (instr[15:12] == 4'b1001) begin
            y = 16'h0000; sel = 2'b10; res = ~x;
        end else begin
            y = instr[5] ? {{11{instr[4]}}, instr[4:0]} : mr[instr[2:0]];
            if (instr[15:12] == 4'b0001) begin
                sel = 2'b00; res = x + y;
            end else begin
                sel = 2'b01; res = x & y;
            end
        end
        e.dr  = instr[11:9];
        e.res = res;
        e.nzp = nzp_of(res);
        sb.push_back(e);

        IR          = instr;
        instr_valid = 1'b1;
        if (co_ld) begin
            ld_en = 1'b1; ld_addr = la; ld_data = ldv;
        end
        @(posedge Clk); #1;
        instr_valid = 1'b0;
        ld_en       = 1'b0;
        check_val("ready_busy", instr_ready, 1'b0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            @(posedge Clk); #1;
            n++;
            if (n == 1) begin
                check_val("exec_x",   alu_X,   x);
                check_val("exec_y",   alu_Y,   y);
                check_val("exec_sel", alu_sel, sel);
                if (exec_ld) begin
                    ld_en = 1'b1; ld_addr = la; ld_data = ldv;
                end
            end
            if (done) seen = 1'b1;
        end
        ld_en = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            check_val("done_timeout", 0, 1);
        end else begin
            check_val("latency", n, 3);
            dbg_addr = e.dr;
            #1;
            check_val("wb_data", dbg_data, e.res);
            check_val("wb_nzp",  nzp,      e.nzp);
            mr[e.dr] = e.res;
            m_nzp    = e.nzp;
            @(posedge Clk); #1;
            check_val("done_width", done, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset_n = 1'b0; instr_valid = 1'b0; IR = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        for (int i = 0; i < 8; i++) mr[i] = 16'h0000;
        m_nzp = 3'b000;
        #2;
        check_val("rst_ready", instr_ready, 1'b1);
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        check_val("rst_done",    done,    1'b0);
        check_val("rst_illegal", illegal, 1'b0);
        check_val("rst_nzp",     nzp,     3'b000);
        check_val("rst_sel",     alu_sel, 2'b11);
        check_val("rst_x",       alu_X,   16'h0000);
        check_val("rst_y",       alu_Y,   16'h0000);
        check_regs("rst");

        // ADD R0,R1,R2
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        issue(16'h1042, 1'b0, 1'b0, 3'd0, 16'h0);
        // ADD R3,R1,#-5
        issue(16'h167B, 1'b0, 1'b0, 3'd0, 16'h0);
        // NOT R4,R4 then AND R5,R4,#15
        preload(3'd4, 16'h00F0);
        issue(16'h993F, 1'b0, 1'b0, 3'd0, 16'h0);
        issue(16'h5B2F, 1'b0, 1'b0, 3'd0, 16'h0);
        // ADD R1,R1,#1 wraps
        preload(3'd1, 16'hFFFF);
        issue(16'h1261, 1'b0, 1'b0, 3'd0, 16'h0);

        // Illegal opcode: one-cycle pulse, nothing else changes
        IR = 16'h0000; instr_valid = 1'b1;
        @(posedge Clk); #1;
        instr_valid = 1'b0;
        check_val("ill_pulse", illegal,     1'b1);
        check_val("ill_ready", instr_ready, 1'b1);
        check_val("ill_done",  done,        1'b0);
        @(posedge Clk); #1;
        check_val("ill_width", illegal, 1'b0);
        check_val("ill_done2", done,    1'b0);
        check_val("ill_nzp",   nzp,     m_nzp);
        check_regs("ill");

        // ADD R6,R1,R2 with a preload of R7 attempted during EXEC/WB
        issue(16'h1C42, 1'b0, 1'b1, 3'd7, 16'hBEEF);
        check_regs("busy_ld");

        // Preload R2 on the same edge as ADD R0,R1,R2 accepts
        issue(16'h1042, 1'b1, 1'b0, 3'd2, 16'h0010);

        // Reset during EXEC aborts ADD R0,R1,R2
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        IR = 16'h1042; instr_valid = 1'b1;
        @(posedge Clk); #1;
        instr_valid = 1'b0;
        @(posedge Clk); #1;
        check_val("abort_in_exec", alu_sel, 2'b00);
        Reset_n = 1'b0;
        #1;
        check_val("abort_ready", instr_ready, 1'b1);
        check_val("abort_done",  done,        1'b0);
        for (int i = 0; i < 8; i++) mr[i] = 16'h0000;
        m_nzp = 3'b000;
        repeat (2) begin
            @(posedge Clk); #1;
            check_val("abort_done_rst", done, 1'b0);
        end
        Reset_n = 1'b1;
        repeat (3) begin
            @(posedge Clk); #1;
            check_val("abort_done_post", done, 1'b0);
        end
        check_val("abort_nzp", nzp, 3'b000);
        check_regs("abort");

        // First acceptance after reset behaves normally
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        issue(16'h1042, 1'b0, 1'b0, 3'd0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
